store_unit: RTL and testbench

Data-memory store path for the non-pipelined LEGv8 core, the write-direction counterpart of the writeback load-extract logic. It accepts one store request (STUR, STURW, STURH, STURB) from the memory stage and drives a word-only data memory port with no byte strobes. Sub-doubleword stores are done as read-modify-write; doubleword stores are a single write. The core stalls on `req_ready` low.

---
 rtl/store_unit_pkg.sv | 47 ++++
 rtl/store_merge.sv | 32 +++
 rtl/store_unit.sv | 107 ++++++++++
 tb/tb_store_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared constants for the LEGv8 data-memory store path: size and FSM
// encodings plus the STUR-family opcode to store-size mapping.
package store_unit_pkg;

  localparam int WORD_W    = 64;
  localparam int ADDR_BITS = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [10:0] OP_STUR  = 11'h7C0;
  localparam logic [10:0] OP_STURW = 11'h5C0;
  localparam logic [10:0] OP_STURH = 11'h3C0;
  localparam logic [10:0] OP_STURB = 11'h1C0;

  function automatic size_e opcode_size(input logic [10:0] opcode);
    case (opcode)
      OP_STURB: return SZ_B;
      OP_STURH: return SZ_H;
      OP_STURW: return SZ_W;
      OP_STUR:  return SZ_D;
      default:  return SZ_D;
    endcase
  endfunction

  // Natural alignment: the field must not straddle its own size boundary.
  function automatic logic is_aligned(input size_e size, input logic [2:0] offset);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return offset[0] == 1'b0;
      SZ_W:    return offset[1:0] == 2'b00;
      default: return offset == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational little-endian merge of a right-aligned 8/16/32/64-bit field
// into an existing doubleword at a byte offset.
module store_merge
  import store_unit_pkg::*;
#(
  parameter int WORD = WORD_W
) (
  input  logic [WORD-1:0] old_word,
  input  logic [WORD-1:0] new_data,
  input  size_e           size,
  input  logic [2:0]      offset,
  output logic [WORD-1:0] merged
);

  logic [WORD-1:0] field_mask;
  logic [WORD-1:0] lane_mask;
  logic [5:0]      shamt;

  always_comb begin
    case (size)
      SZ_B:    field_mask = WORD'(64'h0000_0000_0000_00FF);
      SZ_H:    field_mask = WORD'(64'h0000_0000_0000_FFFF);
      SZ_W:    field_mask = WORD'(64'h0000_0000_FFFF_FFFF);
      default: field_mask = '1;
    endcase
  end

  assign shamt     = {offset, 3'b000};
  assign lane_mask = field_mask << shamt;
  assign merged    = (old_word & ~lane_mask) | ((new_data & field_mask) << shamt);

endmodule

// File: rtl/store_unit.sv
// Store path for a word-only data memory: doubleword stores write directly,
// narrower stores read-modify-write, misaligned stores are rejected.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int WORD   = WORD_W,
  parameter int ADDR_W = ADDR_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD-1:0]   req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD-1:0]   mem_wdata,
  input  logic [WORD-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err_misaligned
);

  state_e          state_q, state_d;
  logic [WORD-1:0] data_q;
  size_e           size_q;
  logic [2:0]      off_q;
  logic            err_q;
  logic [WORD-1:0] merged;
  size_e           req_sz;
  logic            req_ok;

  assign req_sz = size_e'(req_size);
  assign req_ok = is_aligned(req_sz, req_addr[2:0]);

  store_merge #(.WORD(WORD)) u_merge (
    .old_word (mem_rdata),
    .new_data (data_q),
    .size     (size_q),
    .offset   (off_q),
    .merged   (merged)
  );

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    state_d        = state_q;
    req_ready      = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    done           = 1'b0;
    err_misaligned = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_ok)            state_d = ST_DONE;
          else if (req_sz == SZ_D) state_d = ST_WRITE;
          else                    state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_rd = 1'b1;
        if (mem_ack) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr = 1'b1;
        if (mem_ack) state_d = ST_DONE;
      end
      default: begin
        done           = 1'b1;
        err_misaligned = err_q;
        state_d        = ST_IDLE;
      end
    endcase
  end

  // The write word is loaded either straight from the request (doubleword)
  // or from the merge result on the read ack, so mem_wdata is stable in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      data_q    <= '0;
      size_q    <= SZ_B;
      off_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
        data_q   <= req_data;
        size_q   <= req_sz;
        off_q    <= req_addr[2:0];
        err_q    <= !req_ok;
        if (req_ok && req_sz == SZ_D) mem_wdata <= req_data;
      end
      if (state_q == ST_READ && mem_ack) mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: table-driven stores against a memory
// responder with programmable ack latency and a write scoreboard.
module tb_store_unit;
  import store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic [63:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        done;
  logic        err_misaligned;

  store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_size       (req_size),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .done           (done),
    .err_misaligned (err_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
  } wr_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    size_e       size;
    logic [63:0] old;
    logic [63:0] exp_wdata;
    bit          exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_delay = 0;
  int          wr_delay = 0;
  int          wr_acks  = 0;
  wr_t         exp_q[$];
  logic [63:0] mm [logic [63:0]];
  vec_t        vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after the programmed number of wait cycles and
  // checks each acked write against the scoreboard.
  initial begin
    int  wait_cnt;
    wr_t e;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_rd || mem_wr) begin
        if (wait_cnt == (mem_rd ? rd_delay : wr_delay)) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_rd) begin
            mem_rdata = mm.exists(mem_addr) ? mm[mem_addr] : 64'h0;
          end else begin
            wr_acks++;
            if (exp_q.size() == 0) begin
              check("sb_unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
              e = exp_q.pop_front();
              check("sb_wr_addr", mem_addr, e.addr);
              check("sb_wr_data", mem_wdata, e.wdata);
            end
            mm[mem_addr] = mem_wdata;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_store(input string name, input logic [63:0] addr, input logic [63:0] data,
                          input size_e size, input logic [63:0] exp_wdata, input bit exp_err,
                          input bit pulse_mid);
    logic [63:0] line;
    int          exp_lat, lat, viol, rd_cyc, wr_cyc;
    bit          got;
    line    = {addr[63:3], 3'b000};
    exp_lat = exp_err ? 1 : (size == SZ_D ? wr_delay + 2 : rd_delay + wr_delay + 3);
    lat = 0; viol = 0; rd_cyc = 0; wr_cyc = 0;
    if (!exp_err) exp_q.push_back('{line, exp_wdata});

    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    check({name, "_ready_wait"}, 64'(got), 64'd1);
    if (!got) return;
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;

    got = 1'b0;
    for (int i = 1; i <= 64 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
      end
      if (pulse_mid && i == 2) begin
        req_valid = 1'b1;
        req_addr  = 64'h41;
        req_data  = 64'h5555;
        req_size  = SZ_H;
      end
      if (pulse_mid && i == 3) req_valid = 1'b0;
      if (mem_rd) rd_cyc++;
      if (mem_wr) wr_cyc++;
      if (mem_rd && mem_wr) viol++;
      if ((mem_rd || mem_wr) && mem_addr !== line) viol++;
      if (mem_wr && mem_wdata !== exp_wdata) viol++;
      if (err_misaligned && !done) viol++;
      if (done) begin
        got = 1'b1;
        lat = i;
        check({name, "_err"}, 64'(err_misaligned), 64'(exp_err));
      end else if (req_ready) begin
        viol++;
      end
    end
    req_valid = 1'b0;
    check({name, "_done_seen"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_rd_cycles"}, 64'(rd_cyc), 64'((exp_err || size == SZ_D) ? 0 : rd_delay + 1));
    check({name, "_wr_cycles"}, 64'(wr_cyc), 64'(exp_err ? 0 : wr_delay + 1));
    check({name, "_violations"}, 64'(viol), 64'd0);
    @(negedge clk);
    check({name, "_done_once"}, 64'(done), 64'd0);
    check({name, "_ready_after"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int dn;
    int wr_before;
    bit seen;

    vecs[0]  = '{64'h40, 64'h1122_3344_5566_7788, SZ_D, 64'h0,                   64'h1122_3344_5566_7788, 1'b0};
    vecs[1]  = '{64'h43, 64'hFFFF_FFFF_FFFF_FFAB, SZ_B, 64'h0,                   64'h0000_0000_AB00_0000, 1'b0};
    vecs[2]  = '{64'h42, 64'hAAAA_0000_0000_1234, SZ_H, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_1234_FFFF, 1'b0};
    vecs[3]  = '{64'h44, 64'h5555_5555_DEAD_BEEF, SZ_W, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{64'h41, 64'h1234,                SZ_H, 64'h0,                   64'h0,                   1'b1};
    vecs[5]  = '{64'h44, 64'h1122_3344_5566_7788, SZ_D, 64'h0,                   64'h0,                   1'b1};
    vecs[6]  = '{64'h80, 64'h5A,                  SZ_B, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CD5A, 1'b0};
    vecs[7]  = '{64'h87, 64'h99,                  SZ_B, 64'h0123_4567_89AB_CDEF, 64'h9923_4567_89AB_CDEF, 1'b0};
    vecs[8]  = '{64'h80, 64'hCAFE_F00D,           SZ_W, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_CAFE_F00D, 1'b0};
    vecs[9]  = '{64'h86, 64'hBEEF,                SZ_H, 64'h0,                   64'hBEEF_0000_0000_0000, 1'b0};
    vecs[10] = '{64'h42, 64'hCAFE_F00D,           SZ_W, 64'h0,                   64'h0,                   1'b1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    #12;
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_misaligned), 64'd0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      mm[{vecs[k].addr[63:3], 3'b000}] = vecs[k].old;
      do_store($sformatf("vec%0d", k), vecs[k].addr, vecs[k].data, vecs[k].size,
               vecs[k].exp_wdata, vecs[k].exp_err, 1'b0);
    end

    // Wait states with a stray request pulsed during the read.
    rd_delay = 3;
    wr_delay = 2;
    mm[64'hC0] = 64'h1111_1111_1111_1111;
    do_store("wait_b", 64'hC5, 64'h77, SZ_B, 64'h1111_7711_1111_1111, 1'b0, 1'b1);
    check("wait_mem_line", mm[64'hC0], 64'h1111_7711_1111_1111);
    mm[64'h100] = 64'h0;
    do_store("wait_d", 64'h100, 64'hA5A5_5A5A_0F0F_F0F0, SZ_D, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1'b0);

    // Async reset while the read strobe is waiting for its ack.
    rd_delay = 20;
    wr_delay = 0;
    mm[64'h140] = 64'h2222_2222_2222_2222;
    wr_before = wr_acks;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = req_ready;
    end
    req_valid = 1'b1;
    req_addr  = 64'h141;
    req_data  = 64'h33;
    req_size  = SZ_B;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      seen = mem_rd;
    end
    check("abort_read_started", 64'(seen), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_rd", 64'(mem_rd), 64'd0);
    check("abort_mem_wr", 64'(mem_wr), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_err", 64'(err_misaligned), 64'd0);
    check("abort_mem_addr", mem_addr, 64'h0);
    check("abort_mem_wdata", mem_wdata, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(req_ready), 64'd1);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);
    check("abort_no_write", 64'(wr_acks - wr_before), 64'd0);
    check("abort_mem_line", mm[64'h140], 64'h2222_2222_2222_2222);

    rd_delay = 0;
    do_store("post_reset", 64'h141, 64'h33, SZ_B, 64'h2222_2222_2222_3322, 1'b0, 1'b0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
